// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code view, a wrap pulse (tc)
// and a per-edge "Gray changed" flag. Load has priority over count enable.
module gray_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             tc,
   output logic             changed
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] next_bin;
   logic [WIDTH-1:0] next_gray;
   logic             next_tc;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      next_bin = bin;
      next_tc  = 1'b0;
      if (load) begin
         next_bin = load_val;
      end else if (en) begin
         if (up) begin
            next_bin = bin + ONE;
            next_tc  = &bin;
         end else begin
            next_bin = bin - ONE;
            next_tc  = ~|bin;
         end
      end
   end

   assign next_gray = next_bin ^ (next_bin >> 1);

   // Gray is encoded from next_bin so it lands on the same edge as bin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin     <= '0;
         gray    <= '0;
         tc      <= 1'b0;
         changed <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         bin     <= next_bin;
         gray    <= next_gray;
         tc      <= next_tc;
         changed <= (next_gray != gray);
      end
   end

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed scenarios plus a randomized
// run, all checked against a reflected-Gray-table reference model.
module tb_gray_counter;

   localparam int W = 4;
   localparam int N = 1 << W;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic         up;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] bin;
   logic [W-1:0] gray;
   logic         tc;
   logic         changed;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state.
   int gray_tab[N];
   int m_bin;
   int m_tc;
   int m_chg;

   gray_counter #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .bin      (bin),
      .gray     (gray),
      .tc       (tc),
      .changed  (changed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".bin"},     32'(bin),     32'(m_bin));
      check({tag, ".gray"},    32'(gray),    32'(gray_tab[m_bin]));
      check({tag, ".tc"},      32'(tc),      32'(m_tc));
      check({tag, ".changed"}, 32'(changed), 32'(m_chg));
   endtask

   // Drive one edge's inputs, advance the model, sample 1 time unit after the edge.
   task automatic step(input logic e, input logic u, input logic l, input int lv, input string tag);
      int prev_g;
      en       = e;
      up       = u;
      load     = l;
      load_val = W'(lv);
      @(posedge clk);
      prev_g = gray_tab[m_bin];
      if (l) begin
         m_bin = lv % N;
         m_tc  = 0;
      end else if (e && u) begin
         m_tc  = (m_bin == N - 1) ? 1 : 0;
         m_bin = (m_bin + 1) % N;
      end else if (e) begin
         m_tc  = (m_bin == 0) ? 1 : 0;
         m_bin = (m_bin + N - 1) % N;
      end else begin
         m_tc  = 0;
      end
      m_chg = (gray_tab[m_bin] != prev_g) ? 1 : 0;
      #1;
      check_model(tag);
   endtask

   initial begin
      int seq_up[16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
      logic [W-1:0] prev_gray;
      logic re, ru, rl;

      // Reflected Gray code table built by mirroring, independent of XOR encoding.
      gray_tab[0] = 0;
      for (int k = 0; k < W; k++)
         for (int i = 0; i < (1 << k); i++)
            gray_tab[(1 << k) + i] = gray_tab[(1 << k) - 1 - i] | (1 << k);

      // Reset.
      rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
      m_bin = 0; m_tc = 0; m_chg = 0;
      #12;
      check_model("reset");
      rst = 1'b0;

      // 1: sixteen up steps with explicit Gray sequence.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b1, 1'b0, 0, "up16");
         check("up16.seq",     32'(gray),    32'(seq_up[i]));
         check("up16.changed", 32'(changed), 32'd1);
         check("up16.tc",      32'(tc),      (i == 15) ? 32'd1 : 32'd0);
      end

      // 2: down wrap from 0.
      step(1'b1, 1'b0, 1'b0, 0, "down_wrap");
      check("down_wrap.bin",  32'(bin),  32'd15);
      check("down_wrap.gray", 32'(gray), 32'd8);
      check("down_wrap.tc",   32'(tc),   32'd1);
      step(1'b1, 1'b0, 1'b0, 0, "down_next");
      check("down_next.gray", 32'(gray), 32'd9);
      check("down_next.tc",   32'(tc),   32'd0);

      // 3: load beats enable.
      step(1'b1, 1'b1, 1'b1, 9, "load9");
      check("load9.gray", 32'(gray), 32'd13);
      step(1'b1, 1'b1, 1'b0, 0, "after_load");
      check("after_load.bin",  32'(bin),  32'd10);
      check("after_load.gray", 32'(gray), 32'd15);

      // 4: hold, then redundant load of the current value.
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b0, 0, "hold");
         check("hold.changed", 32'(changed), 32'd0);
      end
      step(1'b0, 1'b0, 1'b1, 10, "reload");
      check("reload.changed", 32'(changed), 32'd0);

      // 5: asynchronous reset between edges at bin = 6.
      step(1'b0, 1'b0, 1'b1, 5, "preset5");
      step(1'b1, 1'b1, 1'b0, 0, "to6");
      check("to6.bin", 32'(bin), 32'd6);
      #2 rst = 1'b1;
      #1;
      m_bin = 0; m_tc = 0; m_chg = 0;
      check_model("async_rst");
      rst = 1'b0;
      step(1'b1, 1'b1, 1'b0, 0, "post_rst");
      check("post_rst.gray", 32'(gray), 32'd1);

      // 6: randomized en/up/load.
      prev_gray = gray;
      for (int i = 0; i < 1000; i++) begin
         re = 1'($urandom_range(0, 1));
         ru = 1'($urandom_range(0, 1));
         rl = ($urandom_range(0, 7) == 0);
         step(re, ru, rl, int'($urandom_range(0, N - 1)), "rand");
         if (re && !rl)
            check("rand.onebit", 32'($countones(gray ^ prev_gray)), 32'd1);
         prev_gray = gray;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
